// File: rtl/rv32i_ctrl_fsm_if.sv
// Memory-port bundle between the RV32I control FSM and the memory subsystem.
// The FSM issues requests (mem_req/mem_we/addr_sel); memory answers with mem_ready.
interface rv32i_ctrl_fsm_if;
    logic mem_req;
    logic mem_we;
    logic addr_sel;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output addr_sel,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  addr_sel,
        output mem_ready
    );
endinterface

// File: rtl/rv32i_ctrl_fsm.sv
// Multi-cycle control FSM for the RV32I core.
// Sequences FETCH -> DECODE -> EXECUTE -> [MEM] -> WB around a shared ALU and a
// single memory port, decodes datapath strobes from state + opcode, counts
// retired instructions and halts on SYSTEM, an illegal opcode or a bus timeout.
// Strobes are decoded combinationally from the state register so that they line
// up with the cycle the datapath acts in; ir_load also depends on mem_ready.
module rv32i_ctrl_fsm #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned INSTRET_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic [6:0]           opcode,
    input  logic                 take_branch,
    rv32i_ctrl_fsm_if.master     mem,
    output logic                 ir_load,
    output logic                 alu_a_sel,
    output logic                 alu_b_sel,
    output logic                 rf_we,
    output logic [1:0]           wb_sel,
    output logic                 pc_we,
    output logic [1:0]           pc_sel,
    output logic [2:0]           state,
    output logic                 halted,
    output logic                 err_illegal,
    output logic                 err_bus,
    output logic [INSTRET_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_HALT    = 3'd6
    } state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Counter holds at most TIMEOUT_CYCLES-1; the limit is detected one step early.
    localparam int unsigned     TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t                 state_r;
    state_t                 state_next_s;
    logic [TMO_W-1:0]       tmo_cnt_r;
    logic [TMO_W-1:0]       tmo_cnt_next_s;
    logic                   tmo_hit_s;
    logic                   set_ill_s;
    logic                   set_bus_s;
    logic                   inc_instret_s;
    logic                   err_illegal_r;
    logic                   err_bus_r;
    logic [INSTRET_W-1:0]   instret_r;

    logic is_op_s, is_opimm_s, is_load_s, is_store_s, is_branch_s, is_jal_s;
    logic is_jalr_s, is_lui_s, is_auipc_s, is_fence_s, is_system_s, is_legal_s;

    assign is_op_s     = (opcode == OPC_OP);
    assign is_opimm_s  = (opcode == OPC_OPIMM);
    assign is_load_s   = (opcode == OPC_LOAD);
    assign is_store_s  = (opcode == OPC_STORE);
    assign is_branch_s = (opcode == OPC_BRANCH);
    assign is_jal_s    = (opcode == OPC_JAL);
    assign is_jalr_s   = (opcode == OPC_JALR);
    assign is_lui_s    = (opcode == OPC_LUI);
    assign is_auipc_s  = (opcode == OPC_AUIPC);
    assign is_fence_s  = (opcode == OPC_FENCE);
    assign is_system_s = (opcode == OPC_SYSTEM);
    assign is_legal_s  = is_op_s | is_opimm_s | is_load_s | is_store_s | is_branch_s |
                         is_jal_s | is_jalr_s | is_lui_s | is_auipc_s | is_fence_s |
                         is_system_s;

    // A wait cycle that would push the counter to the limit is a timeout, unless memory answers.
    assign tmo_hit_s = (tmo_cnt_r == TMO_LAST) && !mem.mem_ready;

    // Next-state and strobe decode from the current state, opcode and memory handshake.
    always_comb begin
        state_next_s  = state_r;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.addr_sel  = 1'b0;
        ir_load       = 1'b0;
        alu_a_sel     = 1'b0;
        alu_b_sel     = 1'b0;
        rf_we         = 1'b0;
        wb_sel        = 2'd0;
        pc_we         = 1'b0;
        pc_sel        = 2'd0;
        set_ill_s     = 1'b0;
        set_bus_s     = 1'b0;
        inc_instret_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (run) begin
                    state_next_s = S_FETCH;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_FETCH: begin
                mem.mem_req = 1'b1;
                if (mem.mem_ready) begin
                    ir_load      = 1'b1;
                    state_next_s = S_DECODE;
                end else if (tmo_hit_s) begin
                    set_bus_s    = 1'b1;
                    state_next_s = S_HALT;
                end else begin
                    state_next_s = S_FETCH;
                end
            end
            S_DECODE: begin
                if (is_legal_s) begin
                    state_next_s = S_EXECUTE;
                end else begin
                    set_ill_s    = 1'b1;
                    state_next_s = S_HALT;
                end
            end
            S_EXECUTE: begin
                alu_a_sel = is_auipc_s | is_jal_s;
                alu_b_sel = is_op_s | is_branch_s;
                if (is_load_s || is_store_s) begin
                    state_next_s = S_MEM;
                end else if (is_system_s) begin
                    state_next_s = S_HALT;
                end else begin
                    state_next_s = S_WB;
                end
            end
            S_MEM: begin
                alu_a_sel    = is_auipc_s | is_jal_s;
                alu_b_sel    = is_op_s | is_branch_s;
                mem.mem_req  = 1'b1;
                mem.addr_sel = 1'b1;
                mem.mem_we   = is_store_s;
                if (mem.mem_ready) begin
                    state_next_s = S_WB;
                end else if (tmo_hit_s) begin
                    set_bus_s    = 1'b1;
                    state_next_s = S_HALT;
                end else begin
                    state_next_s = S_MEM;
                end
            end
            S_WB: begin
                alu_a_sel     = is_auipc_s | is_jal_s;
                alu_b_sel     = is_op_s | is_branch_s;
                pc_we         = 1'b1;
                inc_instret_s = 1'b1;
                rf_we         = is_op_s | is_opimm_s | is_load_s | is_lui_s |
                                is_auipc_s | is_jal_s | is_jalr_s;
                if (is_jalr_s) begin
                    pc_sel = 2'd2;
                end else if (is_jal_s || (is_branch_s && take_branch)) begin
                    pc_sel = 2'd1;
                end else begin
                    pc_sel = 2'd0;
                end
                if (is_load_s) begin
                    wb_sel = 2'd1;
                end else if (is_jal_s || is_jalr_s) begin
                    wb_sel = 2'd2;
                end else begin
                    wb_sel = 2'd0;
                end
                state_next_s = S_FETCH;
            end
            S_HALT: begin
                state_next_s = S_HALT;
            end
            default: begin
                state_next_s = S_HALT;
            end
        endcase
    end

    // Wait-cycle count: grows only while staying in FETCH/MEM without mem_ready.
    always_comb begin
        if (((state_r == S_FETCH) || (state_r == S_MEM)) && !mem.mem_ready &&
            (state_next_s == state_r)) begin
            tmo_cnt_next_s = tmo_cnt_r + TMO_W'(1);
        end else begin
            tmo_cnt_next_s = {TMO_W{1'b0}};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Bus timeout counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else begin
            tmo_cnt_r <= tmo_cnt_next_s;
        end
    end

    // Sticky error flags; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_illegal_r <= 1'b0;
            err_bus_r     <= 1'b0;
        end else begin
            err_illegal_r <= err_illegal_r | set_ill_s;
            err_bus_r     <= err_bus_r | set_bus_s;
        end
    end

    // Retired-instruction counter, wraps naturally at 2^INSTRET_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            instret_r <= {INSTRET_W{1'b0}};
        end else if (inc_instret_s) begin
            instret_r <= instret_r + INSTRET_W'(1);
        end else begin
            instret_r <= instret_r;
        end
    end

    assign state       = state_r;
    assign halted      = (state_r == S_HALT);
    assign err_illegal = err_illegal_r;
    assign err_bus     = err_bus_r;
    assign instret     = instret_r;

endmodule

// File: tb/tb_rv32i_ctrl_fsm.sv
// Scoreboard bench for rv32i_ctrl_fsm: the stimulus process pushes one
// hand-computed expected snapshot per clock cycle; a monitor on the falling
// edge pops and compares it against the DUT outputs.
module tb_rv32i_ctrl_fsm;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] FENCE  = 7'b0001111;
    localparam logic [6:0] SYSTEM = 7'b1110011;
    localparam logic [6:0] BAD    = 7'b0000000;

    localparam logic [2:0] IDLE = 3'd0, FET = 3'd1, DEC = 3'd2, EXE = 3'd3,
                           MEM = 3'd4, WB = 3'd5, HLT = 3'd6;

    // Strobe fields: req we asel irl | a b rfwe wb[1:0] | pcwe pcsel[1:0]
    localparam logic [11:0] NONE    = 12'b0_0_0_0_0_0_0_00_0_00;
    localparam logic [11:0] F_WAIT  = 12'b1_0_0_0_0_0_0_00_0_00;
    localparam logic [11:0] F_RDY   = 12'b1_0_0_1_0_0_0_00_0_00;
    localparam logic [11:0] E_B     = 12'b0_0_0_0_0_1_0_00_0_00;
    localparam logic [11:0] E_A     = 12'b0_0_0_0_1_0_0_00_0_00;
    localparam logic [11:0] WB_OP   = 12'b0_0_0_0_0_1_1_00_1_00;
    localparam logic [11:0] M_LD    = 12'b1_0_1_0_0_0_0_00_0_00;
    localparam logic [11:0] M_ST    = 12'b1_1_1_0_0_0_0_00_0_00;
    localparam logic [11:0] WB_LD   = 12'b0_0_0_0_0_0_1_01_1_00;
    localparam logic [11:0] WB_BRT  = 12'b0_0_0_0_0_1_0_00_1_01;
    localparam logic [11:0] WB_BRN  = 12'b0_0_0_0_0_1_0_00_1_00;
    localparam logic [11:0] WB_JALR = 12'b0_0_0_0_0_0_1_10_1_10;
    localparam logic [11:0] WB_JAL  = 12'b0_0_0_0_1_0_1_10_1_01;
    localparam logic [11:0] WB_LUI  = 12'b0_0_0_0_0_0_1_00_1_00;
    localparam logic [11:0] WB_NOP  = 12'b0_0_0_0_0_0_0_00_1_00;

    // Flags: {halted, err_illegal, err_bus}
    localparam logic [2:0] F_OK  = 3'b000;
    localparam logic [2:0] F_BUS = 3'b101;
    localparam logic [2:0] F_ILL = 3'b110;
    localparam logic [2:0] F_SYS = 3'b100;

    typedef struct packed {
        logic [2:0]  st;
        logic [11:0] strb;
        logic [2:0]  flg;
        logic [31:0] ir;
    } snap_t;

    logic        clk;
    logic        rst;
    logic        run;
    logic [6:0]  opcode;
    logic        take_branch;
    logic        ir_load, alu_a_sel, alu_b_sel, rf_we, pc_we, halted, err_illegal, err_bus;
    logic [1:0]  wb_sel, pc_sel;
    logic [2:0]  state;
    logic [31:0] instret;

    snap_t sb_q[$];
    string name_q[$];
    snap_t exp_s, act_s;
    string nm;
    int    n_checks = 0;
    int    n_errors = 0;
    logic  done = 1'b0;

    rv32i_ctrl_fsm_if bus ();

    rv32i_ctrl_fsm #(.TIMEOUT_CYCLES(4), .INSTRET_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .opcode      (opcode),
        .take_branch (take_branch),
        .mem         (bus),
        .ir_load     (ir_load),
        .alu_a_sel   (alu_a_sel),
        .alu_b_sel   (alu_b_sel),
        .rf_we       (rf_we),
        .wb_sel      (wb_sel),
        .pc_we       (pc_we),
        .pc_sel      (pc_sel),
        .state       (state),
        .halted      (halted),
        .err_illegal (err_illegal),
        .err_bus     (err_bus),
        .instret     (instret)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Push the expected snapshot for the current cycle, then advance one clock.
    task automatic cyc(input string name, input logic [2:0] st, input logic [11:0] strb,
                       input logic [2:0] flg, input logic [31:0] ir);
        snap_t x;
        x.st   = st;
        x.strb = strb;
        x.flg  = flg;
        x.ir   = ir;
        sb_q.push_back(x);
        name_q.push_back(name);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare one expected snapshot per falling edge, then close out the run.
    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            exp_s = sb_q.pop_front();
            nm    = name_q.pop_front();
            act_s.st   = state;
            act_s.strb = {bus.mem_req, bus.mem_we, bus.addr_sel, ir_load, alu_a_sel, alu_b_sel,
                          rf_we, wb_sel, pc_we, pc_sel};
            act_s.flg  = {halted, err_illegal, err_bus};
            act_s.ir   = instret;
            n_checks++;
            if (act_s !== exp_s) begin
                n_errors++;
                $display("FAIL %s: got state=%0d strb=%b flg=%b instret=%0d, expected state=%0d strb=%b flg=%b instret=%0d",
                         nm, act_s.st, act_s.strb, act_s.flg, act_s.ir,
                         exp_s.st, exp_s.strb, exp_s.flg, exp_s.ir);
            end
        end else if (done) begin
            n_checks++;
            if (name_q.size() != 0) begin
                n_errors++;
                $display("FAIL drain: got %0d leftover entries, expected 0", name_q.size());
            end
            $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
            $finish;
        end
    end

    initial begin
        rst = 1'b1; run = 1'b0; opcode = BAD; take_branch = 1'b0; bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        cyc("reset", IDLE, NONE, F_OK, 32'd0);
        rst = 1'b0;
        cyc("idle_norun", IDLE, NONE, F_OK, 32'd0);

        // OP with zero-wait memory: 4-cycle instruction.
        run = 1'b1; bus.mem_ready = 1'b1; opcode = OP;
        cyc("op_idle", IDLE, NONE, F_OK, 32'd0);
        cyc("op_fetch", FET, F_RDY, F_OK, 32'd0);
        cyc("op_dec", DEC, NONE, F_OK, 32'd0);
        cyc("op_exe", EXE, E_B, F_OK, 32'd0);
        cyc("op_wb", WB, WB_OP, F_OK, 32'd0);

        // LOAD with three memory wait cycles.
        opcode = LOAD;
        cyc("ld_fetch", FET, F_RDY, F_OK, 32'd1);
        cyc("ld_dec", DEC, NONE, F_OK, 32'd1);
        cyc("ld_exe", EXE, NONE, F_OK, 32'd1);
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("ld_mem_wait", MEM, M_LD, F_OK, 32'd1);
        bus.mem_ready = 1'b1;
        cyc("ld_mem_done", MEM, M_LD, F_OK, 32'd1);
        cyc("ld_wb", WB, WB_LD, F_OK, 32'd1);

        // Branch taken, branch not taken, JALR, JAL.
        opcode = BRANCH; take_branch = 1'b1;
        cyc("brt_fetch", FET, F_RDY, F_OK, 32'd2);
        cyc("brt_dec", DEC, NONE, F_OK, 32'd2);
        cyc("brt_exe", EXE, E_B, F_OK, 32'd2);
        cyc("brt_wb", WB, WB_BRT, F_OK, 32'd2);
        take_branch = 1'b0;
        cyc("brn_fetch", FET, F_RDY, F_OK, 32'd3);
        cyc("brn_dec", DEC, NONE, F_OK, 32'd3);
        cyc("brn_exe", EXE, E_B, F_OK, 32'd3);
        cyc("brn_wb", WB, WB_BRN, F_OK, 32'd3);
        opcode = JALR; take_branch = 1'b1;
        cyc("jalr_fetch", FET, F_RDY, F_OK, 32'd4);
        cyc("jalr_dec", DEC, NONE, F_OK, 32'd4);
        cyc("jalr_exe", EXE, NONE, F_OK, 32'd4);
        cyc("jalr_wb", WB, WB_JALR, F_OK, 32'd4);
        opcode = JAL; take_branch = 1'b0;
        cyc("jal_fetch", FET, F_RDY, F_OK, 32'd5);
        cyc("jal_dec", DEC, NONE, F_OK, 32'd5);
        cyc("jal_exe", EXE, E_A, F_OK, 32'd5);
        cyc("jal_wb", WB, WB_JAL, F_OK, 32'd5);

        // Fetch answered on the 4th cycle: just under the timeout, no error.
        opcode = LUI; bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("lui_fetch_wait", FET, F_WAIT, F_OK, 32'd6);
        bus.mem_ready = 1'b1;
        cyc("lui_fetch_edge", FET, F_RDY, F_OK, 32'd6);
        cyc("lui_dec", DEC, NONE, F_OK, 32'd6);
        cyc("lui_exe", EXE, NONE, F_OK, 32'd6);
        cyc("lui_wb", WB, WB_LUI, F_OK, 32'd6);

        // Fetch never answered: bus error after 4 wait cycles.
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) cyc("tmo_wait", FET, F_WAIT, F_OK, 32'd7);
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) cyc("tmo_halt", HLT, NONE, F_BUS, 32'd7);
        rst = 1'b1;
        cyc("rst_in_halt", HLT, NONE, F_BUS, 32'd7);
        rst = 1'b0; run = 1'b0;
        cyc("reset_from_bus", IDLE, NONE, F_OK, 32'd0);

        // Illegal opcode halts after DECODE and stays quiet.
        run = 1'b1; opcode = BAD;
        cyc("ill_idle", IDLE, NONE, F_OK, 32'd0);
        cyc("ill_fetch", FET, F_RDY, F_OK, 32'd0);
        cyc("ill_dec", DEC, NONE, F_OK, 32'd0);
        for (int i = 0; i < 20; i++) begin
            take_branch = i[0];
            cyc("ill_halt", HLT, NONE, F_ILL, 32'd0);
        end
        rst = 1'b1;
        cyc("rst_in_ill", HLT, NONE, F_ILL, 32'd0);
        rst = 1'b0;

        // SYSTEM halts from EXECUTE with no error flag.
        opcode = SYSTEM;
        cyc("sys_idle", IDLE, NONE, F_OK, 32'd0);
        cyc("sys_fetch", FET, F_RDY, F_OK, 32'd0);
        cyc("sys_dec", DEC, NONE, F_OK, 32'd0);
        cyc("sys_exe", EXE, NONE, F_OK, 32'd0);
        cyc("sys_halt", HLT, NONE, F_SYS, 32'd0);
        rst = 1'b1;
        cyc("rst_in_sys", HLT, NONE, F_SYS, 32'd0);
        rst = 1'b0;

        // FENCE retires, then a STORE is reset while its memory request is pending.
        opcode = FENCE;
        cyc("fence_idle", IDLE, NONE, F_OK, 32'd0);
        cyc("fence_fetch", FET, F_RDY, F_OK, 32'd0);
        cyc("fence_dec", DEC, NONE, F_OK, 32'd0);
        cyc("fence_exe", EXE, NONE, F_OK, 32'd0);
        cyc("fence_wb", WB, WB_NOP, F_OK, 32'd0);
        opcode = STORE;
        cyc("st_fetch", FET, F_RDY, F_OK, 32'd1);
        cyc("st_dec", DEC, NONE, F_OK, 32'd1);
        cyc("st_exe", EXE, NONE, F_OK, 32'd1);
        bus.mem_ready = 1'b0;
        cyc("st_mem_wait", MEM, M_ST, F_OK, 32'd1);
        rst = 1'b1;
        cyc("st_mem_rst", MEM, M_ST, F_OK, 32'd1);
        rst = 1'b0; run = 1'b0;
        cyc("st_after_rst", IDLE, NONE, F_OK, 32'd0);
        cyc("idle_hold", IDLE, NONE, F_OK, 32'd0);

        done = 1'b1;
    end

endmodule
